// File: rtl/nn_param_loader_pkg.sv
// ============================================================================
//  Module      : nn_param_loader_pkg
//  Description : Shared sizes, address widths, state encoding and section
//                helpers for the parameter / image stream loader.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package nn_param_loader_pkg;

    // Network geometry
    localparam int N_IN  = 400;
    localparam int N_HID = 20;
    localparam int N_OUT = 10;

    // Words per section, in stream order
    localparam int LEN_W12  = N_IN * N_HID;
    localparam int LEN_B12  = N_HID;
    localparam int LEN_W23  = N_HID * N_OUT;
    localparam int LEN_B23  = N_OUT;
    localparam int LEN_DATA = N_IN;

    // Widths
    localparam int WORD_W  = 16;
    localparam int PIX_W   = 2;
    localparam int IDX_W   = 13;
    localparam int W12_AW  = 13;
    localparam int B12_AW  = 5;
    localparam int W23_AW  = 8;
    localparam int B23_AW  = 4;
    localparam int DATA_AW = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_W12   = 3'd1,
        ST_B12   = 3'd2,
        ST_W23   = 3'd3,
        ST_B23   = 3'd4,
        ST_DATA  = 3'd5,
        ST_START = 3'd6,
        ST_WAIT  = 3'd7
    } state_t;

    // Index value of the final word of the section being loaded
    function automatic logic [IDX_W-1:0] section_last(input state_t st);
        logic [IDX_W-1:0] last;
        last = '0;
        case (st)
            ST_W12:  last = IDX_W'(LEN_W12  - 1);
            ST_B12:  last = IDX_W'(LEN_B12  - 1);
            ST_W23:  last = IDX_W'(LEN_W23  - 1);
            ST_B23:  last = IDX_W'(LEN_B23  - 1);
            ST_DATA: last = IDX_W'(LEN_DATA - 1);
            default: last = '0;
        endcase
        return last;
    endfunction

    // Section that follows the current one; the image section hands over to START
    function automatic state_t section_next(input state_t st);
        state_t nxt;
        nxt = ST_IDLE;
        case (st)
            ST_W12:  nxt = ST_B12;
            ST_B12:  nxt = ST_W23;
            ST_W23:  nxt = ST_B23;
            ST_B23:  nxt = ST_DATA;
            ST_DATA: nxt = ST_START;
            default: nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nn_param_loader.sv
// ============================================================================
//  Module      : nn_param_loader
//  Description : Converts a 16-bit valid/ready word stream into sequential
//                writes for the w12/b12/w23/b23/image memories, then starts
//                the inference engine and stays busy until it reports done.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module nn_param_loader
    import nn_param_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load_req,
    input  logic                 i_image_only,
    input  logic                 i_s_valid,
    input  logic [WORD_W-1:0]    i_s_data,
    output logic                 o_s_ready,
    input  logic                 i_infer_done,
    output logic [WORD_W-1:0]    o_w12_wrdata,
    output logic [WORD_W-1:0]    o_b12_wrdata,
    output logic [WORD_W-1:0]    o_w23_wrdata,
    output logic [WORD_W-1:0]    o_b23_wrdata,
    output logic [PIX_W-1:0]     o_wrdata,
    output logic [W12_AW-1:0]    o_wr_w12addr,
    output logic [B12_AW-1:0]    o_wr_b12addr,
    output logic [W23_AW-1:0]    o_wr_w23addr,
    output logic [B23_AW-1:0]    o_wr_b23addr,
    output logic [DATA_AW-1:0]   o_wraddr,
    output logic                 o_we,
    output logic                 o_we_b12,
    output logic                 o_w23_we,
    output logic                 o_b23_we,
    output logic                 o_we_data,
    output logic                 o_start,
    output logic                 o_busy
);

    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [WORD_W-1:0]    r_word;
    logic [W12_AW-1:0]    r_w12addr;
    logic [B12_AW-1:0]    r_b12addr;
    logic [W23_AW-1:0]    r_w23addr;
    logic [B23_AW-1:0]    r_b23addr;
    logic [DATA_AW-1:0]   r_wraddr;
    logic                 r_we_w12;
    logic                 r_we_b12;
    logic                 r_we_w23;
    logic                 r_we_b23;
    logic                 r_we_data;
    logic                 r_s_ready;
    logic                 r_start;
    logic                 r_busy;

    logic                 w_hs;
    logic                 w_last;

    // s_ready is a registered decode of the load states, so it doubles as the
    // "in a load section" qualifier for the handshake
    assign w_hs   = i_s_valid & r_s_ready;
    assign w_last = (r_idx == section_last(r_state));

    // Loader FSM: section sequencing, shared index, registered write strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_word    <= '0;
            r_w12addr <= '0;
            r_b12addr <= '0;
            r_w23addr <= '0;
            r_b23addr <= '0;
            r_wraddr  <= '0;
            r_we_w12  <= 1'b0;
            r_we_b12  <= 1'b0;
            r_we_w23  <= 1'b0;
            r_we_b23  <= 1'b0;
            r_we_data <= 1'b0;
            r_s_ready <= 1'b0;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            // Strobes and start are single-cycle pulses
            r_we_w12  <= 1'b0;
            r_we_b12  <= 1'b0;
            r_we_w23  <= 1'b0;
            r_we_b23  <= 1'b0;
            r_we_data <= 1'b0;
            r_start   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (i_load_req) begin
                        r_busy    <= 1'b1;
                        r_s_ready <= 1'b1;
                        r_idx     <= '0;
                        r_state   <= i_image_only ? ST_DATA : ST_W12;
                    end
                end

                ST_W12, ST_B12, ST_W23, ST_B23, ST_DATA: begin
                    if (w_hs) begin
                        r_word <= i_s_data;
                        case (r_state)
                            ST_W12: begin
                                r_we_w12  <= 1'b1;
                                r_w12addr <= r_idx[W12_AW-1:0];
                            end
                            ST_B12: begin
                                r_we_b12  <= 1'b1;
                                r_b12addr <= r_idx[B12_AW-1:0];
                            end
                            ST_W23: begin
                                r_we_w23  <= 1'b1;
                                r_w23addr <= r_idx[W23_AW-1:0];
                            end
                            ST_B23: begin
                                r_we_b23  <= 1'b1;
                                r_b23addr <= r_idx[B23_AW-1:0];
                            end
                            default: begin
                                r_we_data <= 1'b1;
                                r_wraddr  <= r_idx[DATA_AW-1:0];
                            end
                        endcase

                        if (w_last) begin
                            r_idx   <= '0;
                            r_state <= section_next(r_state);
                            // Final image word: stop accepting before START
                            if (r_state == ST_DATA) begin
                                r_s_ready <= 1'b0;
                            end
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end

                ST_START: begin
                    r_start <= 1'b1;
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (i_infer_done) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // All weight/bias data ports follow the last accepted word
    assign o_w12_wrdata = r_word;
    assign o_b12_wrdata = r_word;
    assign o_w23_wrdata = r_word;
    assign o_b23_wrdata = r_word;
    assign o_wrdata     = r_word[PIX_W-1:0];

    assign o_wr_w12addr = r_w12addr;
    assign o_wr_b12addr = r_b12addr;
    assign o_wr_w23addr = r_w23addr;
    assign o_wr_b23addr = r_b23addr;
    assign o_wraddr     = r_wraddr;

    assign o_we         = r_we_w12;
    assign o_we_b12     = r_we_b12;
    assign o_w23_we     = r_we_w23;
    assign o_b23_we     = r_we_b23;
    assign o_we_data    = r_we_data;

    assign o_s_ready    = r_s_ready;
    assign o_start      = r_start;
    assign o_busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_nn_param_loader.sv
// ============================================================================
//  Module      : tb_nn_param_loader
//  Description : Randomised scoreboard bench for nn_param_loader.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nn_param_loader;

    localparam int N_IN  = 400;
    localparam int N_HID = 20;
    localparam int N_OUT = 10;
    localparam int FULL_WORDS = N_IN * N_HID + N_HID + N_HID * N_OUT + N_OUT + N_IN;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_req;
    logic        image_only;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        infer_done;
    logic [15:0] w12_wrdata, b12_wrdata, w23_wrdata, b23_wrdata;
    logic [1:0]  wrdata;
    logic [12:0] wr_w12addr;
    logic [4:0]  wr_b12addr;
    logic [7:0]  wr_w23addr;
    logic [3:0]  wr_b23addr;
    logic [8:0]  wraddr;
    logic        we, we_b12, w23_we, b23_we, we_data;
    logic        start;
    logic        busy;

    nn_param_loader u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load_req   (load_req),
        .i_image_only (image_only),
        .i_s_valid    (s_valid),
        .i_s_data     (s_data),
        .o_s_ready    (s_ready),
        .i_infer_done (infer_done),
        .o_w12_wrdata (w12_wrdata),
        .o_b12_wrdata (b12_wrdata),
        .o_w23_wrdata (w23_wrdata),
        .o_b23_wrdata (b23_wrdata),
        .o_wrdata     (wrdata),
        .o_wr_w12addr (wr_w12addr),
        .o_wr_b12addr (wr_b12addr),
        .o_wr_w23addr (wr_w23addr),
        .o_wr_b23addr (wr_b23addr),
        .o_wraddr     (wraddr),
        .o_we         (we),
        .o_we_b12     (we_b12),
        .o_w23_we     (w23_we),
        .o_b23_we     (b23_we),
        .o_we_data    (we_data),
        .o_start      (start),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr  = 0;
    int n_start = 0;

    typedef struct {
        int sec;
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];

    function automatic logic [63:0] pack(input wr_t w);
        return {8'(w.sec), 24'(w.addr), 32'(w.data)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: position k of a load -> (section, address) from section sizes
    function automatic void model(input bit img, input int k, output int sec, output int addr);
        int lens[5];
        int r;
        lens = '{N_IN * N_HID, N_HID, N_HID * N_OUT, N_OUT, N_IN};
        sec  = 4;
        addr = k;
        if (img) return;
        r = k;
        for (int s = 0; s < 5; s++) begin
            if (r < lens[s]) begin
                sec  = s;
                addr = r;
                return;
            end
            r -= lens[s];
        end
    endfunction

    // Monitor: every visible strobe is one write, matched in order to the queue
    int  mon_ns;
    wr_t mon_g;
    wr_t mon_e;
    always @(negedge clk) begin
        mon_ns = int'(we) + int'(we_b12) + int'(w23_we) + int'(b23_we) + int'(we_data);
        if (mon_ns != 0) begin
            chk("one_strobe", 64'(mon_ns), 64'd1);
            n_wr++;
            if (we) begin
                mon_g.sec = 0; mon_g.addr = int'(wr_w12addr); mon_g.data = int'(w12_wrdata);
            end else if (we_b12) begin
                mon_g.sec = 1; mon_g.addr = int'(wr_b12addr); mon_g.data = int'(b12_wrdata);
            end else if (w23_we) begin
                mon_g.sec = 2; mon_g.addr = int'(wr_w23addr); mon_g.data = int'(w23_wrdata);
            end else if (b23_we) begin
                mon_g.sec = 3; mon_g.addr = int'(wr_b23addr); mon_g.data = int'(b23_wrdata);
            end else begin
                mon_g.sec = 4; mon_g.addr = int'(wraddr);     mon_g.data = int'(wrdata);
            end
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got sec %0d addr %0d data 0x%0h, expected no write",
                         mon_g.sec, mon_g.addr, mon_g.data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write", pack(mon_g), pack(mon_e));
            end
        end
        if (start) n_start++;
    end

    function automatic int out_ones();
        return $countones({we, we_b12, w23_we, b23_we, we_data, s_ready, start, busy,
                           wr_w12addr, wr_b12addr, wr_w23addr, wr_b23addr, wraddr,
                           w12_wrdata, b12_wrdata, w23_wrdata, b23_wrdata, wrdata});
    endfunction

    // Drive one load; pat 0: word = address, 1: 0x0003, 2: random.
    // inj_k pulses load_req with word k; stop_k returns after stop_k handshakes.
    task automatic run_load(input bit img, input int gap_pct, input int pat,
                            input int inj_k, input int stop_k, output int lat);
        int total, sec, addr, word, t0, budget;
        lat   = -1;
        total = img ? N_IN : FULL_WORDS;
        load_req   = 1'b1;
        image_only = img;
        @(posedge clk); #1;
        load_req   = 1'b0;
        image_only = 1'b0;
        t0 = int'(cyc);
        for (int k = 0; k < total; k++) begin
            if (k == stop_k) begin
                s_valid = 1'b0;
                return;
            end
            model(img, k, sec, addr);
            word = (pat == 0) ? addr : (pat == 1) ? 3 : int'($urandom_range(0, 65535));
            while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = word[15:0];
            if (k == inj_k) load_req = 1'b1;
            budget = 0;
            while (!s_ready && budget < 20) begin
                @(posedge clk); #1;
                budget++;
            end
            if (!s_ready) begin
                chk("handshake_timeout", 64'(s_ready), 64'd1);
                s_valid  = 1'b0;
                load_req = 1'b0;
                return;
            end
            exp_q.push_back('{sec, addr, (sec == 4) ? (word & 3) : word});
            @(posedge clk); #1;
            load_req = 1'b0;
        end
        s_valid = 1'b0;
        chk("s_ready_drop", 64'(s_ready), 64'd0);
        budget = 0;
        while (!start && budget < 10) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("start_seen", 64'(start), 64'd1);
        lat = int'(cyc) - t0;
    endtask

    // Hold done low for a number of cycles after start, then return it
    task automatic finish_engine(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (i == 0) chk("start_one_cycle", 64'(start), 64'd0);
            chk("wait_busy", 64'(busy), 64'd1);
            chk("wait_no_ready", 64'(s_ready), 64'd0);
        end
        infer_done = 1'b1;
        @(posedge clk); #1;
        infer_done = 1'b0;
        chk("busy_clear", 64'(busy), 64'd0);
    endtask

    int lat;
    int wr0;
    int st0;

    initial begin
        rst_n      = 1'b0;
        load_req   = 1'b0;
        image_only = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        infer_done = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'(out_ones()), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_outputs", 64'(out_ones()), 64'd0);

        // A: full back-to-back load, word = address; done held low 50 cycles
        wr0 = n_wr; st0 = n_start;
        run_load(1'b0, 0, 0, -1, -1, lat);
        chk("full_latency", 64'(lat), 64'(FULL_WORDS + 1));
        finish_engine(50);
        chk("full_writes", 64'(n_wr - wr0), 64'(FULL_WORDS));
        chk("full_starts", 64'(n_start - st0), 64'd1);
        chk("full_queue_empty", 64'(exp_q.size()), 64'd0);

        // B: image only, pattern 0x0003, done already high on entry to WAIT
        repeat (2) @(posedge clk);
        #1;
        wr0 = n_wr; st0 = n_start;
        infer_done = 1'b1;
        run_load(1'b1, 0, 1, -1, -1, lat);
        chk("img_latency", 64'(lat), 64'(N_IN + 1));
        chk("img_busy_in_wait", 64'(busy), 64'd1);
        @(posedge clk); #1;
        chk("img_early_done", 64'(busy), 64'd0);
        chk("img_start_one_cycle", 64'(start), 64'd0);
        infer_done = 1'b0;
        chk("img_writes", 64'(n_wr - wr0), 64'(N_IN));
        chk("img_starts", 64'(n_start - st0), 64'd1);

        // C: 50% valid gaps, random words, load_req in B23 and in WAIT
        repeat (2) @(posedge clk);
        #1;
        wr0 = n_wr; st0 = n_start;
        run_load(1'b0, 50, 2, N_IN * N_HID + N_HID + N_HID * N_OUT + 5, -1, lat);
        @(posedge clk); #1;
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        finish_engine(5);
        repeat (3) @(posedge clk);
        #1;
        chk("gap_idle_no_ready", 64'(s_ready), 64'd0);
        chk("gap_writes", 64'(n_wr - wr0), 64'(FULL_WORDS));
        chk("gap_starts", 64'(n_start - st0), 64'd1);
        chk("gap_queue_empty", 64'(exp_q.size()), 64'd0);

        // D: reset at W23 index 100 aborts the load on the same edge
        run_load(1'b0, 0, 2, -1, N_IN * N_HID + N_HID + 100, lat);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", 64'(out_ones()), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // E: fresh full load after abort starts again at w12 address 0
        wr0 = n_wr; st0 = n_start;
        run_load(1'b0, 0, 2, -1, -1, lat);
        chk("reload_latency", 64'(lat), 64'(FULL_WORDS + 1));
        finish_engine(2);
        chk("reload_writes", 64'(n_wr - wr0), 64'(FULL_WORDS));
        chk("reload_starts", 64'(n_start - st0), 64'd1);
        chk("reload_queue_empty", 64'(exp_q.size()), 64'd0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/nn_param_loader.md
# nn_param_loader

Front-end writer for the digit-recognition inference engine. Accepts a single 16-bit valid/ready word stream and converts it into the sequential write transactions for the w12, b12, w23, b23 and input-data memories. When loading completes, it issues a one-cycle `start` to the engine and reports `busy` until the engine's `done` returns. It sits between the host/stream source and the engine's memory write ports.

## Interface
- `N_IN`, 400, input pixels (data memory depth)
- `N_HID`, 20, hidden neurons
- `N_OUT`, 10, output classes
- `clk`  in  1  clock; everything sampled on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `load_req`  in  1  one-cycle request to begin a load; ignored unless IDLE
- `image_only`  in  1  sampled with `load_req`; 1 = skip weights/biases, load DATA only
- `s_valid`  in  1  stream word valid
- `s_data`  in  16  stream word, q6.10 for weights/biases; bits [1:0] only for DATA
- `s_ready`  out  1  loader can accept a word
- `infer_done`  in  1  engine `done`
- `w12_wrdata`, `b12_wrdata`, `w23_wrdata`, `b23_wrdata`  out  16 each  write data
- `wrdata`  out  2  data-memory write data
- `wr_w12addr` out 13, `wr_b12addr` out 5, `wr_w23addr` out 8, `wr_b23addr` out 4, `wraddr` out 9  write addresses
- `we`, `we_b12`, `w23_we`, `b23_we`, `we_data`  out  1 each  write strobes, at most one high per cycle
- `start`  out  1  one-cycle engine start pulse
- `busy`  out  1  high from accepted `load_req` until `infer_done` is seen

## Operation
- States: IDLE, W12, B12, W23, B23, DATA, START, WAIT.
- IDLE: `s_ready`=0. On `load_req`, go to W12, or to DATA if `image_only`=1. Set `busy`.
- Section lengths: W12 = N_IN*N_HID (8000), B12 = N_HID (20), W23 = N_HID*N_OUT (200), B23 = N_OUT (10), DATA = N_IN (400). Fixed order W12→B12→W23→B23→DATA.
- In W12..DATA, `s_ready`=1. Each handshake (`s_valid`&`s_ready`) writes the word to the current section at address = running index, starting at 0. The index increments by one per handshake.
- The last word of a section moves the FSM to the next section and clears the index. If that word is the last DATA word, go to START.
- Stall: when `s_valid`=0, no write occurs and the index holds.
- DATA: `wrdata` = `s_data[1:0]`; bits [15:2] are ignored.
- START: `start`=1 for exactly one cycle, then WAIT.
- WAIT: hold until `infer_done`=1, then IDLE, `busy`=0. A `load_req` during WAIT or any load state is ignored.
- Address ports hold their last value when no strobe is active. Data ports follow the registered word.

## Timing
- Reset value of every output is 0, state = IDLE, index = 0.
- Write latency: the strobe, address and data are all registered. They appear the cycle after the handshake, one write per handshake, back-to-back at full rate.
- `s_ready` is a registered state decode. It drops in the cycle after the final DATA handshake, so no word is accepted in START or WAIT.
- `start` is asserted in the cycle after the final DATA write strobe.
- If `infer_done` is already high on entry to WAIT, exit on that cycle.
- Reset asserted mid-load aborts the load immediately: strobes go to 0 asynchronously and no partial write completes. A fresh `load_req` restarts from index 0.
- Full load at 100% `s_valid`: 8630 accept cycles, plus one cycle to `start`.

## Structure
- The shared package holds:
  - N_IN, N_HID, N_OUT
  - the derived section lengths
  - the address widths
  - the state enum
- One module, no sub-modules. A single 13-bit index counter is shared across sections; each address port takes the low bits of the index.

## Test plan
- Full load with continuous `s_valid`, words = index value:
  - w12 gets 8000 writes, last at addr 7999 with data 7999;
  - then b12 0..19, w23 0..199, b23 0..9, data 0..399;
  - `start` is one pulse, 8631 cycles after `load_req`.
- `image_only`=1 with 400 words of pattern 0x0003: only `we_data` toggles, `wrdata`=2'b11, `wraddr` 0..399. `start` pulses once.
- Random `s_valid` gaps (50%): write sequence identical to the back-to-back case, and no strobe is ever asserted without a handshake.
- `load_req` in B23 and in WAIT: ignored, and the section counts are unchanged.
- `reset` low at W23 index 100: all outputs 0 on the same edge. A new full load then starts at w12 addr 0.
- `infer_done` held low 50 cycles after `start`: `busy`=1 throughout, `s_ready`=0. `busy`=0 the cycle after `infer_done`.
